// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one synchronous-read RAM between the CPU port (A)
// and the UART-monitor port (B). Single grant per cycle, round-robin on ties,
// monitor lock that shuts out A, pipelined one-cycle read return and an
// A-port starvation status for debug.
//
// Handshake: a port raises x_req with x_we/x_adr/x_wdata and holds them stable
// until it sees x_gnt high in a cycle; the transfer happens in that cycle.
// A granted read returns x_rvalid=1 with x_rdata exactly one cycle later.
// x_rdata is unqualified and only meaningful while x_rvalid=1.
module dram_port_arbiter #(
   parameter int ADR_W = 12,
   parameter int DAT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   // CPU port
   input  logic             a_req,
   input  logic             a_we,
   input  logic [ADR_W-1:0] a_adr,
   input  logic [DAT_W-1:0] a_wdata,
   output logic             a_gnt,
   output logic             a_rvalid,
   output logic [DAT_W-1:0] a_rdata,
   // UART-monitor port
   input  logic             b_req,
   input  logic             b_we,
   input  logic [ADR_W-1:0] b_adr,
   input  logic [DAT_W-1:0] b_wdata,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [DAT_W-1:0] b_rdata,
   // monitor owns the RAM
   input  logic             mon_lock,
   // RAM side
   output logic [ADR_W-1:0] ram_radr,
   output logic [ADR_W-1:0] ram_wadr,
   output logic [DAT_W-1:0] ram_wdata,
   output logic             ram_wen,
   input  logic [DAT_W-1:0] ram_rdata,
   // debug status
   output logic             a_starve
);

   logic             r_last_b;      // 1: B was granted most recently
   logic             r_gnt_seen;    // 0 until the first grant after reset
   logic             r_rd_pend;     // a granted read returns this cycle
   logic             r_rd_owner_b;  // owner of the returning read
   logic [ADR_W-1:0] r_radr_hold;
   logic [ADR_W-1:0] r_wadr_hold;
   logic [3:0]       r_starve_cnt;

   logic             w_a_pref;
   logic             w_a_gnt;
   logic             w_b_gnt;
   logic             w_gnt_we;
   logic [ADR_W-1:0] w_gnt_adr;

   // Grant decision and RAM drive from the granted port, all combinational.
   // Ties go to the port not granted most recently; before any grant has been
   // made A wins, which is why r_gnt_seen is kept alongside r_last_b.
   always_comb begin
      w_a_pref  = !r_gnt_seen || r_last_b;
      w_a_gnt   = !rst && !mon_lock && a_req && (!b_req || w_a_pref);
      w_b_gnt   = !rst && b_req && !w_a_gnt;
      w_gnt_we  = w_b_gnt ? b_we  : a_we;
      w_gnt_adr = w_b_gnt ? b_adr : a_adr;

      a_gnt     = w_a_gnt;
      b_gnt     = w_b_gnt;
      ram_wen   = (w_a_gnt || w_b_gnt) && w_gnt_we;
      ram_wdata = w_b_gnt ? b_wdata : a_wdata;
      ram_wadr  = ((w_a_gnt || w_b_gnt) && w_gnt_we)  ? w_gnt_adr : r_wadr_hold;
      ram_radr  = ((w_a_gnt || w_b_gnt) && !w_gnt_we) ? w_gnt_adr : r_radr_hold;

      // Returning read goes to its owner; reset cancels it in the same cycle.
      a_rvalid  = !rst && r_rd_pend && !r_rd_owner_b;
      b_rvalid  = !rst && r_rd_pend &&  r_rd_owner_b;
      a_rdata   = ram_rdata;
      b_rdata   = ram_rdata;

      a_starve  = !rst && r_starve_cnt[3];
   end

   // Round-robin history: updated only when a grant is made.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_b   <= 1'b0;
         r_gnt_seen <= 1'b0;
      end else if (w_a_gnt || w_b_gnt) begin
         r_last_b   <= w_b_gnt;
         r_gnt_seen <= 1'b1;
      end
   end

   // Read pipeline: remember that a read was granted and by which port.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_pend    <= 1'b0;
         r_rd_owner_b <= 1'b0;
      end else begin
         r_rd_pend    <= (w_a_gnt || w_b_gnt) && !w_gnt_we;
         r_rd_owner_b <= w_b_gnt;
      end
   end

   // Address hold copies so the RAM addresses stay put while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_radr_hold <= '0;
         r_wadr_hold <= '0;
      end else begin
         r_radr_hold <= ram_radr;
         r_wadr_hold <= ram_wadr;
      end
   end

   // A-port wait counter, saturating at 15, cleared on grant or dropped request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= 4'd0;
      end else if (a_req && !w_a_gnt) begin
         if (r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
         r_starve_cnt <= 4'd0;
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: behavioural RAM, reference memory, read-return
// scoreboard keyed by expected cycle, directed scenarios plus random traffic.
module tb_dram_port_arbiter;

   localparam int ADR_W = 12;
   localparam int DAT_W = 32;
   localparam int EW    = 16 + 1 + DAT_W;  // {due cycle, port, data}

   logic             clk = 1'b0;
   logic             rst;
   logic             a_req, a_we, a_gnt, a_rvalid;
   logic [ADR_W-1:0] a_adr;
   logic [DAT_W-1:0] a_wdata, a_rdata;
   logic             b_req, b_we, b_gnt, b_rvalid;
   logic [ADR_W-1:0] b_adr;
   logic [DAT_W-1:0] b_wdata, b_rdata;
   logic             mon_lock;
   logic [ADR_W-1:0] ram_radr, ram_wadr;
   logic [DAT_W-1:0] ram_wdata, ram_rdata;
   logic             ram_wen;
   logic             a_starve;

   logic             preload;
   logic [15:0]      cyc = 16'd0;
   logic [DAT_W-1:0] mem     [0:(1<<ADR_W)-1];
   logic [DAT_W-1:0] ref_mem [0:(1<<ADR_W)-1];
   logic [EW-1:0]    exp_q[$];
   int               n_checks = 0;
   int               n_errors = 0;

   dram_port_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mon_lock(mon_lock),
      .ram_radr(ram_radr), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
      .ram_wen(ram_wen), .ram_rdata(ram_rdata),
      .a_starve(a_starve)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 16'd1;

   function automatic logic [DAT_W-1:0] init_val(int i);
      if (i == 'h010) return 32'h0000_0011;
      if (i == 'h020) return 32'h0000_0022;
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
   endfunction

   // behavioural RAM: synchronous read, data one cycle after address
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < (1<<ADR_W); i++) mem[i] <= init_val(i);
      end else begin
         ram_rdata <= mem[ram_radr];
         if (ram_wen) mem[ram_wadr] <= ram_wdata;
      end
   end

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endfunction

   // reference model: writes update ref_mem, reads queue their expected return
   function automatic void record(input logic p, input logic we,
                                  input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] d);
      if (we) ref_mem[adr] = d;
      else    exp_q.push_back({cyc + 16'd1, p, ref_mem[adr]});
   endfunction

   // driver: present a request on port p and hold it until granted
   task automatic port_do(input logic p, input logic we,
                          input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] d);
      int   n;
      logic g;
      n = 0;
      g = 1'b0;
      if (p) begin b_req = 1'b1; b_we = we; b_adr = adr; b_wdata = d; end
      else   begin a_req = 1'b1; a_we = we; a_adr = adr; a_wdata = d; end
      forever begin
         @(negedge clk);
         g = p ? b_gnt : a_gnt;
         if (g) break;
         n++;
         if (n > 200) break;
         @(posedge clk); #1;
      end
      if (g) record(p, we, adr, d);
      else   chk("grant_timeout", 64'(g), 64'(1));
      @(posedge clk); #1;
      if (p) b_req = 1'b0; else a_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // monitor: one grant per cycle, read returns matched against the queue
   always @(negedge clk) begin
      logic [EW-1:0] e;
      chk("two_grants", 64'(a_gnt & b_gnt), 64'(0));
      if (a_rvalid || b_rvalid) begin
         chk("two_rvalids", 64'(a_rvalid & b_rvalid), 64'(0));
         if (exp_q.size() == 0) begin
            chk("rvalid_unexpected", 64'({a_rvalid, b_rvalid}), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("rvalid_cycle", 64'(cyc), 64'(e[EW-1:DAT_W+1]));
            chk("rvalid_port", 64'(b_rvalid), 64'(e[DAT_W]));
            chk("rdata", 64'(b_rvalid ? b_rdata : a_rdata), 64'(e[DAT_W-1:0]));
         end
      end else if (exp_q.size() != 0 && exp_q[0][EW-1:DAT_W+1] == cyc) begin
         e = exp_q.pop_front();
         chk("rvalid_missing", 64'(0), 64'(1));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      for (int i = 0; i < (1<<ADR_W); i++) ref_mem[i] = init_val(i);
      rst = 1'b1; preload = 1'b1; mon_lock = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_adr = '0; a_wdata = '0;
      b_req = 1'b1; b_we = 1'b0; b_adr = '0; b_wdata = '0;
      repeat (2) @(posedge clk);
      #1 preload = 1'b0;

      // reset: requests present but nothing granted, outputs at reset values
      @(negedge clk);
      chk("rst_a_gnt", 64'(a_gnt), 64'(0));
      chk("rst_b_gnt", 64'(b_gnt), 64'(0));
      chk("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
      chk("rst_wen", 64'(ram_wen), 64'(0));
      chk("rst_starve", 64'(a_starve), 64'(0));
      chk("rst_radr", 64'(ram_radr), 64'(0));
      chk("rst_wadr", 64'(ram_wadr), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
      chk("post_rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
      chk("post_rst_wen", 64'(ram_wen), 64'(0));
      @(posedge clk); #1;

      // continuous reads on both ports: A wins the first tie, then alternate
      for (int i = 0; i < 6; i++) begin
         a_req = 1'b1; a_we = 1'b0; a_adr = 12'h100 + 12'(i);
         b_req = 1'b1; b_we = 1'b0; b_adr = 12'h200 + 12'(i);
         @(negedge clk);
         chk("rr_a_gnt", 64'(a_gnt), 64'(i % 2 == 0));
         chk("rr_b_gnt", 64'(b_gnt), 64'(i % 2 == 1));
         if (a_gnt) record(1'b0, 1'b0, a_adr, '0);
         if (b_gnt) record(1'b1, 1'b0, b_adr, '0);
         @(posedge clk); #1;
      end
      a_req = 1'b0; b_req = 1'b0;

      // simultaneous reads of 0x010 (A) and 0x020 (B): A first, then B
      fork
         port_do(1'b0, 1'b0, 12'h010, '0);
         port_do(1'b1, 1'b0, 12'h020, '0);
      join
      idle(2);

      // lone A write: same-cycle RAM write strobe, no read return
      a_req = 1'b1; a_we = 1'b1; a_adr = 12'h004; a_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_a_gnt", 64'(a_gnt), 64'(1));
      chk("wr_b_gnt", 64'(b_gnt), 64'(0));
      chk("wr_wen", 64'(ram_wen), 64'(1));
      chk("wr_wadr", 64'(ram_wadr), 64'(12'h004));
      chk("wr_wdata", 64'(ram_wdata), 64'(32'hDEAD_BEEF));
      if (a_gnt) record(1'b0, 1'b1, a_adr, a_wdata);
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      chk("wr_no_rvalid", 64'(a_rvalid), 64'(0));
      chk("idle_wen", 64'(ram_wen), 64'(0));
      chk("idle_wadr_hold", 64'(ram_wadr), 64'(12'h004));
      @(posedge clk); #1;
      port_do(1'b0, 1'b0, 12'h004, '0);

      // A read then immediate monitor lock: the read still returns to A,
      // B owns every cycle, A starves, counter saturates
      port_do(1'b0, 1'b0, 12'h010, '0);
      mon_lock = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_adr = 12'h020;
      b_req = 1'b1; b_we = 1'b0; b_adr = 12'h030;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         chk("lock_a_gnt", 64'(a_gnt), 64'(0));
         chk("lock_b_gnt", 64'(b_gnt), 64'(1));
         chk("lock_starve", 64'(a_starve), 64'(i >= 9));
         if (b_gnt) record(1'b1, 1'b0, b_adr, '0);
         @(posedge clk); #1;
         b_adr = b_adr + 12'd1;
      end
      mon_lock = 1'b0;
      @(negedge clk);
      chk("unlock_a_gnt", 64'(a_gnt), 64'(1));
      chk("unlock_b_gnt", 64'(b_gnt), 64'(0));
      chk("unlock_starve_held", 64'(a_starve), 64'(1));
      if (a_gnt) record(1'b0, 1'b0, a_adr, '0);
      @(posedge clk); #1;
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
      chk("unlock_starve_clr", 64'(a_starve), 64'(0));
      @(posedge clk); #1;

      // reset right after a granted B read: its return is cancelled
      b_req = 1'b1; b_we = 1'b0; b_adr = 12'h020;
      @(negedge clk);
      chk("cancel_b_gnt", 64'(b_gnt), 64'(1));
      @(posedge clk); #1;
      b_req = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("cancel_b_rvalid", 64'(b_rvalid), 64'(0));
      chk("cancel_gnts", 64'({a_gnt, b_gnt}), 64'(0));
      chk("cancel_wen", 64'(ram_wen), 64'(0));
      chk("cancel_starve", 64'(a_starve), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("cancel_after_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
      chk("cancel_after_radr", 64'(ram_radr), 64'(0));
      chk("cancel_after_wadr", 64'(ram_wadr), 64'(0));
      @(posedge clk); #1;

      // random mixed traffic on a small address window
      fork
         for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            port_do(1'b0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom());
         end
         for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            port_do(1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom());
         end
      join
      idle(4);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
